// File: rtl/btn_debounce_pkg.sv
// Shared types and width helper for the push-button debounce / pulse block.
// The state encoding is fixed so it can be probed on a logic analyser.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // One counter width covers every timing parameter so dcnt and rcnt never wrap
    function automatic int calc_cnt_w(input int debounce_cycles,
                                      input int repeat_delay,
                                      input int repeat_rate);
        int max_v;
        max_v = debounce_cycles;
        if (repeat_delay > max_v) max_v = repeat_delay;
        if (repeat_rate > max_v) max_v = repeat_rate;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset to 0.
// Generic width so any asynchronous level input can reuse it.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Turns a raw bouncy push-button into single-cycle event pulses with optional
// auto-repeat while held, and exports the debounced level.
module btn_debounce_pulse
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_o,
    output logic repeat_o,
    output logic level_o
);

    localparam int CNT_W = calc_cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic btn_s;

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] dcnt_q,   dcnt_d;
    logic [CNT_W-1:0] rcnt_q,   rcnt_d;
    logic             phase_q,  phase_d;
    logic             pulse_q,  pulse_d;
    logic             repeat_q, repeat_d;
    logic             level_q,  level_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            dcnt_q   <= '0;
            rcnt_q   <= '0;
            phase_q  <= 1'b0;
            pulse_q  <= 1'b0;
            repeat_q <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            rcnt_q   <= rcnt_d;
            phase_q  <= phase_d;
            pulse_q  <= pulse_d;
            repeat_q <= repeat_d;
            level_q  <= level_d;
        end
    end

    // dcnt counts agreeing samples; rcnt times the repeat delay (phase 0) then the rate (phase 1)
    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        rcnt_d   = rcnt_q;
        phase_d  = phase_q;
        pulse_d  = 1'b0;
        repeat_d = 1'b0;
        level_d  = level_q;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                level_d = 1'b0;
                if (!btn_s) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    phase_d = 1'b0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end

            HELD: begin
                level_d = 1'b1;
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = CNT_ONE;
                    rcnt_d  = '0;
                end else if (REPEAT_EN != 0) begin
                    if ((!phase_q && (rcnt_q == DELAY_LAST)) ||
                        ( phase_q && (rcnt_q == RATE_LAST))) begin
                        pulse_d  = 1'b1;
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                        phase_d  = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + CNT_ONE;
                    end
                end
            end

            RELEASE_WAIT: begin
                level_d = 1'b1;
                if (btn_s) begin
                    state_d = HELD;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    phase_d = 1'b0;
                end else if (dcnt_q == DB_LAST) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                    level_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                dcnt_d  = '0;
                rcnt_d  = '0;
                phase_d = 1'b0;
                level_d = 1'b0;
            end
        endcase
    end

    assign pulse_o  = pulse_q;
    assign repeat_o = repeat_q;
    assign level_o  = level_q;

endmodule
